gpio_input_port: RTL and testbench

//  Memory-mapped GPIO input peripheral, the read-side counterpart of the GPIO output port.

---
 rtl/gpio_input_port_if.sv | 13 +
 rtl/gpio_input_port.sv | 134 +++++++++++++
 tb/tb_gpio_input_port.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gpio_input_port_if.sv
// Read bus between the core and the GPIO input port: address/strobe from the core,
// registered result and valid pulse back from the peripheral.
interface gpio_input_port_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] Address;
    logic                 Read_en;
    logic [BIT_WIDTH-1:0] Read_data;
    logic                 Read_valid;

    modport master (output Address, output Read_en, input Read_data, input Read_valid);
    modport slave  (input Address, input Read_en, output Read_data, output Read_valid);
endinterface

// File: rtl/gpio_input_port.sv
// GPIO input peripheral: per-pin sync + debounce lanes, sticky change status with
// interrupt, and a registered address-decoded read port.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic toggle
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          meta, sync_q, stable_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            state  <= state_n;
            cnt    <= cnt_n;
            stable <= stable_n;
        end
    end

    // A change is accepted only after sync_q has differed from stable for
    // DEBOUNCE_CYCLES+1 consecutive samples; any agreement restarts the count.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stable_n = stable;
        toggle   = 1'b0;
        case (state)
            IDLE: begin
                if (sync_q != stable) begin
                    state_n = COUNT;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            COUNT: begin
                if (sync_q == stable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    stable_n = sync_q;
                    toggle   = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

module gpio_input_port #(
    parameter int                   BIT_WIDTH       = 32,
    parameter int                   PORT_WIDTH      = 8,
    parameter logic [BIT_WIDTH-1:0] DATA_ADDR       = 32'h1001_0030,
    parameter logic [BIT_WIDTH-1:0] STAT_ADDR       = 32'h1001_0034,
    parameter int                   DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] GPIO_PORT_IN,
    gpio_input_port_if.slave      bus,
    output logic                  Irq
);
    logic [PORT_WIDTH-1:0] stable, toggle, stat, stat_n;
    logic [BIT_WIDTH-1:0]  rd_data;
    logic                  rd_valid, hit_data, hit_stat;

    gpio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [PORT_WIDTH-1:0] (
        .clk    (clk),
        .rst    (rst),
        .pin    (GPIO_PORT_IN),
        .stable (stable),
        .toggle (toggle)
    );

    // A toggle landing on the same edge as a status read survives the clear.
    always_comb begin
        hit_data = bus.Read_en && (bus.Address == DATA_ADDR);
        hit_stat = bus.Read_en && (bus.Address == STAT_ADDR);
        stat_n   = (stat & ~{PORT_WIDTH{hit_stat}}) | toggle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat     <= '0;
            Irq      <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            stat <= stat_n;
            Irq  <= |stat;
            if (bus.Read_en) begin
                if (hit_data) begin
                    rd_data  <= BIT_WIDTH'(stable);
                    rd_valid <= 1'b1;
                end else if (hit_stat) begin
                    rd_data  <= BIT_WIDTH'(stat);
                    rd_valid <= 1'b1;
                end else begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign bus.Read_data  = rd_data;
    assign bus.Read_valid = rd_valid;
endmodule

// File: tb/tb_gpio_input_port.sv
// Scoreboarded bench for gpio_input_port: expected read results are queued at issue
// and matched against each Read_valid pulse; side outputs are checked inline.
module tb_gpio_input_port;
    localparam logic [31:0] DATA_ADDR = 32'h1001_0030;
    localparam logic [31:0] STAT_ADDR = 32'h1001_0034;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pins;
    logic       Irq;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [31:0] exp_q[$];

    gpio_input_port_if #(.BIT_WIDTH(32)) bus ();

    gpio_input_port dut (
        .clk          (clk),
        .rst          (rst),
        .GPIO_PORT_IN (pins),
        .bus          (bus),
        .Irq          (Irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.Read_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [31:0] addr, input bit ours, input logic [31:0] exp);
        bus.Address = addr;
        bus.Read_en = 1'b1;
        if (ours) exp_q.push_back(exp);
    endtask

    // Every valid pulse must match the oldest outstanding expected read.
    always @(posedge clk) begin
        #1;
        if (bus.Read_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("read_data", bus.Read_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        pins = 8'h00;
        bus.Address = '0;
        bus.Read_en = 1'b0;
        ticks(3);
        chk("rst_data", bus.Read_data, 32'h0);
        chk("rst_valid", {31'd0, bus.Read_valid}, 32'd0);
        chk("rst_irq", {31'd0, Irq}, 32'd0);
        rst = 1'b1;

        // Test 1: data read after reset
        rd(DATA_ADDR, 1, 32'h0);
        tick();
        chk("t1_irq", {31'd0, Irq}, 32'd0);

        // Test 3: 10-cycle glitch on bit0 rejected
        pins = 8'h01;
        ticks(10);
        pins = 8'h00;
        ticks(30);
        rd(DATA_ADDR, 1, 32'h0);
        tick();
        rd(STAT_ADDR, 1, 32'h0);
        tick();
        chk("t3_irq", {31'd0, Irq}, 32'd0);

        // Test 2: clean step to A5; stable updates on the 19th edge
        pins = 8'hA5;
        ticks(18);
        chk("t2_irq_early", {31'd0, Irq}, 32'd0);
        rd(DATA_ADDR, 1, 32'h0);
        tick();
        chk("t2_irq_setedge", {31'd0, Irq}, 32'd0);
        rd(DATA_ADDR, 1, 32'hA5);
        tick();
        chk("t2_irq", {31'd0, Irq}, 32'd1);

        // Test 4: read-to-clear status
        rd(STAT_ADDR, 1, 32'hA5);
        tick();
        chk("t4_irq_hold", {31'd0, Irq}, 32'd1);
        tick();
        chk("t4_irq_drop", {31'd0, Irq}, 32'd0);
        rd(STAT_ADDR, 1, 32'h0);
        tick();

        // Test 5: status read coincident with bit3 rise / bit7 fall
        pins = 8'h2D;
        ticks(18);
        rd(STAT_ADDR, 1, 32'h0);
        tick();
        rd(STAT_ADDR, 1, 32'h88);
        tick();
        chk("t5_irq", {31'd0, Irq}, 32'd1);
        rd(DATA_ADDR, 1, 32'h2D);
        tick();
        tick();
        chk("hold_data", bus.Read_data, 32'h2D);
        chk("hold_valid", {31'd0, bus.Read_valid}, 32'd0);
        chk("t5_irq_clr", {31'd0, Irq}, 32'd0);

        // Foreign address: no valid, data zeroed
        rd(32'h1001_0038, 0, 32'h0);
        tick();
        chk("other_data", bus.Read_data, 32'h0);
        chk("other_valid", {31'd0, bus.Read_valid}, 32'd0);

        // Test 6: reset mid-debounce with a read pending
        rd(DATA_ADDR, 1, 32'h2D);
        tick();
        pins = 8'hFF;
        ticks(8);
        bus.Address = DATA_ADDR;
        bus.Read_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6_data", bus.Read_data, 32'h0);
        chk("t6_valid", {31'd0, bus.Read_valid}, 32'd0);
        @(posedge clk);
        #2;
        chk("t6_valid_held", {31'd0, bus.Read_valid}, 32'd0);
        bus.Read_en = 1'b0;
        rst = 1'b1;
        ticks(19);
        chk("t6_irq_early", {31'd0, Irq}, 32'd0);
        rd(STAT_ADDR, 1, 32'hFF);
        tick();
        chk("t6_irq", {31'd0, Irq}, 32'd1);
        rd(DATA_ADDR, 1, 32'hFF);
        tick();
        ticks(2);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
